// File: rtl/apb_master_q.sv
// Queued APB4 master: request FIFO feeding an IDLE/SETUP/ACCESS state machine, one response per transfer.
// Optional wait-state watchdog compiled in with APB_MASTER_Q_TIMEOUT_EN.
module apb_master_q #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_strb,
    input  logic [2:0]            req_prot,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    output logic [2:0]            PPROT,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if ((DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("apb_master_q: illegal parameter combination");
    end

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
        logic [2:0]            prot;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    req_t                  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr, r_rptr;
    logic [PTR_W:0]        r_count;
    state_t                r_state, w_next;
    logic                  w_full, w_empty, w_push, w_pop, w_done, w_tmo;
    req_t                  w_head;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_WIDTH-1:0] r_pstrb;
    logic [2:0]            r_pprot;
    logic                  r_rsp_valid, r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    assign w_full    = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = req_valid && !w_full;
    assign w_head    = r_mem[r_rptr];
    assign req_ready = !w_full;

    // Storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge PCLK) begin
        if (w_push)
            r_mem[r_wptr] <= '{wr: req_write, addr: req_addr, wdata: req_wdata,
                               strb: req_strb, prot: req_prot};
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef APB_MASTER_Q_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES);
    logic [WCNT_W-1:0] r_wait;
    logic              r_rsp_timeout;

    // r_wait holds the number of PREADY=0 cycles already spent in this ACCESS phase.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                              r_wait <= '0;
        else if (r_state == S_SETUP)               r_wait <= '0;
        else if (r_state == S_ACCESS && !PREADY)   r_wait <= r_wait + 1'b1;
    end

    assign w_tmo = (r_state == S_ACCESS) && !PREADY && (r_wait == WCNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_rsp_timeout <= 1'b0;
        else          r_rsp_timeout <= w_tmo;
    end
    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_tmo       = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_SETUP;
                    w_pop  = 1'b1;
                end
            end
            S_SETUP: w_next = S_ACCESS;
            S_ACCESS: begin
                if (PREADY || w_tmo) begin
                    w_done = 1'b1;
                    // Chain straight into the next SETUP so queued transfers never idle.
                    if (!w_empty) begin
                        w_next = S_SETUP;
                        w_pop  = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
        end else if (w_pop) begin
            r_pwrite <= w_head.wr;
            r_paddr  <= w_head.addr;
            r_pwdata <= w_head.wdata;
            r_pstrb  <= w_head.wr ? w_head.strb : '0;
            r_pprot  <= w_head.prot;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done;
            r_rsp_rdata <= (w_done && !r_pwrite && !w_tmo) ? PRDATA : '0;
            r_rsp_err   <= w_done && ((PREADY && PSLVERR) || w_tmo);
        end
    end

    assign PSEL      = (r_state != S_IDLE);
    assign PENABLE   = (r_state == S_ACCESS);
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign PPROT     = r_pprot;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
endmodule
